// File: rtl/uart_pkg.sv
// Shared constants for the oversampling UART receiver: FSM state encoding,
// parity modes and the expected-parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HUNT   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // data must be zero-extended by the caller so unused upper bits add nothing
  function automatic logic exp_parity(input logic [8:0] data, input int mode);
    return (^data) ^ (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Serial line, enable and received-word/status bundle of the UART receiver.
interface uart_rx_os_if #(parameter int DATA_BITS = 8);
  logic                 rx;
  logic                 tx_rx_start;
  logic                 rx_done;
  logic [DATA_BITS-1:0] data_out;
  logic                 parity_bit;
  logic                 parity_err;
  logic                 frame_err;
  logic                 break_det;
  logic [2:0]           current_state_rx;

  modport master (
    output rx, tx_rx_start,
    input  rx_done, data_out, parity_bit, parity_err, frame_err, break_det,
           current_state_rx
  );

  modport slave (
    input  rx, tx_rx_start,
    output rx_done, data_out, parity_bit, parity_err, frame_err, break_det,
           current_state_rx
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// Input synchroniser, free-running bit-phase counter and mid-bit 3-sample
// majority vote. bit_tick marks the cycle where bit_val is the voted bit.
module uart_rx_sampler #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk_baud,
  input  logic rst,
  input  logic rx,
  input  logic restart,
  output logic rx_s,
  output logic bit_val,
  output logic bit_tick
);

  localparam int SCW = $clog2(OVERSAMPLE);
  localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);
  localparam logic [SCW-1:0] MID_LO  = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] MID     = SCW'(OVERSAMPLE / 2);
  localparam logic [SCW-1:0] MID_HI  = SCW'(OVERSAMPLE / 2 + 1);

  logic           sync1, sync2;
  logic           smp_lo, smp_mid;
  logic [SCW-1:0] sc;

  always_ff @(posedge clk_baud) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      sc      <= '0;
      smp_lo  <= 1'b1;
      smp_mid <= 1'b1;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
      if (restart || sc == SC_LAST) sc <= '0;
      else                          sc <= sc + SCW'(1);
      if (sc == MID_LO) smp_lo  <= sync2;
      if (sc == MID)    smp_mid <= sync2;
    end
  end

  // third sample is the live synchronised value at MID+1
  assign rx_s     = sync2;
  assign bit_tick = (sc == MID_HI);
  assign bit_val  = (smp_lo & smp_mid) | (smp_lo & sync2) | (smp_mid & sync2);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: frame FSM over the sampler's voted bits, with
// parity, framing and break detection reported alongside the received word.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1
) (
  input logic          clk_baud,
  input logic          rst,
  uart_rx_os_if.slave  bus
);

  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam logic [BCW-1:0] BC_DATA_LAST = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] BC_STOP_LAST = BCW'(STOP_BITS - 1);

  state_e               state, nxt;
  logic                 rx_s, bit_val, bit_tick;
  logic                 restart, last_stop, brk;
  logic [DATA_BITS-1:0] shreg;
  logic [BCW-1:0]       bc;
  logic                 par_rx, ferr_p, all_zero;

  uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
    .clk_baud (clk_baud),
    .rst      (rst),
    .rx       (bus.rx),
    .restart  (restart),
    .rx_s     (rx_s),
    .bit_val  (bit_val),
    .bit_tick (bit_tick)
  );

  assign brk                  = all_zero & ~bit_val;
  assign bus.current_state_rx = state;

  always_comb begin
    nxt       = state;
    restart   = 1'b0;
    last_stop = 1'b0;
    if (!bus.tx_rx_start) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE:   if (rx_s) nxt = HUNT;
        HUNT:   if (!rx_s) begin
                  nxt     = START;
                  restart = 1'b1;
                end
        START:  if (bit_tick) nxt = bit_val ? HUNT : DATA;
        DATA:   if (bit_tick && bc == BC_DATA_LAST)
                  nxt = (PARITY_MODE == PARITY_NONE) ? STOP : PARITY;
        PARITY: if (bit_tick) nxt = STOP;
        // done is flagged on the last stop decision, not the stop bit's end,
        // so a back-to-back start edge is still seen from HUNT
        STOP:   if (bit_tick && bc == BC_STOP_LAST) begin
                  last_stop = 1'b1;
                  nxt       = brk ? IDLE : HUNT;
                end
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_baud) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge clk_baud) begin
    if (rst) begin
      shreg          <= '0;
      bc             <= '0;
      par_rx         <= 1'b0;
      ferr_p         <= 1'b0;
      all_zero       <= 1'b0;
      bus.rx_done    <= 1'b0;
      bus.data_out   <= '0;
      bus.parity_bit <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.break_det  <= 1'b0;
    end else begin
      bus.rx_done <= 1'b0;
      if (bus.tx_rx_start && bit_tick) begin
        case (state)
          START: if (!bit_val) begin
                   bc       <= '0;
                   par_rx   <= 1'b0;
                   ferr_p   <= 1'b0;
                   all_zero <= 1'b1;
                 end
          DATA: begin
            shreg    <= {bit_val, shreg[DATA_BITS-1:1]};
            all_zero <= all_zero & ~bit_val;
            bc       <= (bc == BC_DATA_LAST) ? '0 : bc + BCW'(1);
          end
          PARITY: begin
            par_rx   <= bit_val;
            all_zero <= all_zero & ~bit_val;
          end
          STOP: begin
            ferr_p   <= ferr_p | ~bit_val;
            all_zero <= all_zero & ~bit_val;
            bc       <= bc + BCW'(1);
            if (last_stop) begin
              bus.rx_done    <= 1'b1;
              bus.data_out   <= shreg;
              bus.parity_bit <= par_rx;
              bus.parity_err <= (PARITY_MODE != PARITY_NONE) &&
                                (par_rx != exp_parity(9'(shreg), PARITY_MODE));
              bus.frame_err  <= ferr_p | ~bit_val;
              bus.break_det  <= brk;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: three configurations, a frame-level model
// queue checked on every cycle, plus hand-computed spot checks.
module tb_uart_rx_os;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_os_if #(.DATA_BITS(8)) ifa ();
  uart_rx_os_if #(.DATA_BITS(8)) ifb ();
  uart_rx_os_if #(.DATA_BITS(7)) ifc ();

  uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(1), .STOP_BITS(1))
    u_a (.clk_baud(clk), .rst(rst), .bus(ifa));
  uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(2), .STOP_BITS(1))
    u_b (.clk_baud(clk), .rst(rst), .bus(ifb));
  uart_rx_os #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(2))
    u_c (.clk_baud(clk), .rst(rst), .bus(ifc));

  typedef struct packed {
    logic [8:0] d;
    logic       pb, pe, fe, bd;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  exp_t held [3];
  int   pulses [3];
  int   n_cmp = 0, n_fail = 0;
  bit   chk_en = 1'b0;

  // expected result of one frame from the bits actually put on the line
  function automatic exp_t model(input int dbits, input int pmode, input int sbits,
                                 input logic [8:0] d, input logic pb, input logic [1:0] stops);
    exp_t e;
    logic [8:0] dm;
    logic stop_ok, stop_zero;
    dm        = d & ((9'd1 << dbits) - 9'd1);
    stop_ok   = (sbits == 2) ? (&stops) : stops[0];
    stop_zero = (sbits == 2) ? ~(|stops) : ~stops[0];
    e.d  = dm;
    e.pb = (pmode == 0) ? 1'b0 : pb;
    e.pe = (pmode != 0) && (pb != ((^dm) ^ (pmode == 2)));
    e.fe = ~stop_ok;
    e.bd = (dm == 9'd0) && (pmode == 0 || !pb) && stop_zero;
    return e;
  endfunction

  function automatic logic [15:0] frame_bits(input int dbits, input int pmode, input int sbits,
                                             input logic [8:0] d, input logic pb,
                                             input logic [1:0] stops, output int n);
    logic [15:0] f;
    f    = '1;
    f[0] = 1'b0;
    n    = 1;
    for (int i = 0; i < dbits; i++) begin f[n] = d[i]; n++; end
    if (pmode != 0) begin f[n] = pb; n++; end
    for (int i = 0; i < sbits; i++) begin f[n] = stops[i]; n++; end
    return f;
  endfunction

  task automatic set_rx(input int k, input logic v);
    case (k)
      0:       ifa.rx = v;
      1:       ifb.rx = v;
      default: ifc.rx = v;
    endcase
  endtask

  task automatic set_en(input int k, input logic v);
    case (k)
      0:       ifa.tx_rx_start = v;
      1:       ifb.tx_rx_start = v;
      default: ifc.tx_rx_start = v;
    endcase
  endtask

  function automatic logic [2:0] state_of(input int k);
    case (k)
      0:       return ifa.current_state_rx;
      1:       return ifb.current_state_rx;
      default: return ifc.current_state_rx;
    endcase
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic push(input int k, input exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic lit(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check(input int k, input logic done, input exp_t got);
    exp_t e;
    if (done === 1'b1) begin
      pulses[k]++;
      if (qsize(k) == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_rx_done inst%0d: got pulse expected none", k);
        return;
      end
      case (k)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      held[k] = e;
    end else if (done !== 1'b0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL rx_done_unknown inst%0d: got %b expected 0/1", k, done);
    end
    n_cmp++;
    if (got !== held[k]) begin
      n_fail++;
      $display("FAIL outputs inst%0d: got d=%0h pb=%b pe=%b fe=%b bd=%b expected d=%0h pb=%b pe=%b fe=%b bd=%b",
               k, got.d, got.pb, got.pe, got.fe, got.bd,
               held[k].d, held[k].pb, held[k].pe, held[k].fe, held[k].bd);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check(0, ifa.rx_done, exp_t'({9'(ifa.data_out), ifa.parity_bit, ifa.parity_err, ifa.frame_err, ifa.break_det}));
      check(1, ifb.rx_done, exp_t'({9'(ifb.data_out), ifb.parity_bit, ifb.parity_err, ifb.frame_err, ifb.break_det}));
      check(2, ifc.rx_done, exp_t'({9'(ifc.data_out), ifc.parity_bit, ifc.parity_err, ifc.frame_err, ifc.break_det}));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // each bit held 16 cycles; optional one-cycle glitch at offset 9, or an
  // enable drop at offset 4 of the given frame bit
  task automatic send(input int k, input logic [15:0] f, input int n,
                      input int glitch_bit, input int abort_bit);
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < 16; c++) begin
        logic v;
        @(posedge clk); #1;
        v = f[b];
        if (b == glitch_bit && c == 9) v = ~v;
        set_rx(k, v);
        if (b == abort_bit && c == 4) begin
          set_en(k, 1'b0);
          @(posedge clk); #1;
          lit("abort_state_idle", 16'(state_of(k)), 16'd0);
          set_rx(k, 1'b1);
          return;
        end
      end
    end
  endtask

  task automatic frame(input int k, input int dbits, input int pmode, input int sbits,
                       input logic [8:0] d, input logic pb, input logic [1:0] stops,
                       input int glitch);
    logic [15:0] f;
    int n;
    push(k, model(dbits, pmode, sbits, d, pb, stops));
    f = frame_bits(dbits, pmode, sbits, d, pb, stops, n);
    send(k, f, n, glitch, -1);
  endtask

  task automatic drain(input int k);
    int t;
    t = 0;
    while (qsize(k) != 0 && t < 400) begin
      @(posedge clk);
      t++;
    end
    #1;
    lit("rx_done_arrived", 16'(qsize(k)), 16'd0);
  endtask

  initial begin
    logic [15:0] f;
    int n;
    for (int k = 0; k < 3; k++) begin held[k] = '0; pulses[k] = 0; end
    for (int k = 0; k < 3; k++) begin set_rx(k, 1'b1); set_en(k, 1'b1); end

    // reset, then IDLE -> HUNT on the first free edge
    repeat (2) @(posedge clk);
    #1;
    lit("rst_state_a", 16'(state_of(0)), 16'd0);
    lit("rst_outs_a", 16'({ifa.rx_done, ifa.data_out, ifa.parity_bit, ifa.parity_err,
                           ifa.frame_err, ifa.break_det}), 16'd0);
    lit("rst_outs_c", 16'({ifc.rx_done, ifc.data_out, ifc.parity_bit, ifc.parity_err,
                           ifc.frame_err, ifc.break_det}), 16'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    lit("hunt_after_idle_a", 16'(state_of(0)), 16'd1);
    lit("hunt_after_idle_b", 16'(state_of(1)), 16'd1);
    lit("hunt_after_idle_c", 16'(state_of(2)), 16'd1);
    chk_en = 1'b1;
    idle(20);

    // nominal 0xA5, even parity 0
    frame(0, 8, 1, 1, 9'h0A5, 1'b0, 2'b11, -1);
    drain(0);
    lit("nominal_data", 16'(ifa.data_out), 16'h00A5);
    lit("nominal_flags", 16'({ifa.parity_bit, ifa.parity_err, ifa.frame_err, ifa.break_det}), 16'd0);
    lit("nominal_pulses", 16'(pulses[0]), 16'd1);

    // odd parity expected 1, sent 0
    frame(1, 8, 2, 1, 9'h0A5, 1'b0, 2'b11, -1);
    drain(1);
    lit("odd_parity_err", 16'(ifb.parity_err), 16'd1);
    lit("odd_parity_data", 16'(ifb.data_out), 16'h00A5);

    // 4-cycle low pulse is a false start
    set_rx(0, 1'b0);
    idle(4);
    set_rx(0, 1'b1);
    idle(40);
    lit("false_start_state", 16'(state_of(0)), 16'd1);
    lit("false_start_pulses", 16'(pulses[0]), 16'd1);

    // glitch inside data bit 3 of 0x00 is voted out
    frame(0, 8, 1, 1, 9'h000, 1'b0, 2'b11, 4);
    drain(0);
    lit("glitch_data", 16'(ifa.data_out), 16'h0000);
    lit("glitch_pulses", 16'(pulses[0]), 16'd2);

    // stop bit sent as 0
    frame(0, 8, 1, 1, 9'h055, 1'b0, 2'b10, -1);
    set_rx(0, 1'b1);
    idle(40);
    drain(0);
    lit("framing_data", 16'(ifa.data_out), 16'h0055);
    lit("framing_fe_bd", 16'({ifa.frame_err, ifa.break_det}), 16'b10);

    // line held low 200 cycles
    push(0, model(8, 1, 1, 9'h000, 1'b0, 2'b00));
    set_rx(0, 1'b0);
    idle(190);
    lit("break_waits_idle", 16'(state_of(0)), 16'd0);
    idle(10);
    set_rx(0, 1'b1);
    drain(0);
    lit("break_flags", 16'({ifa.data_out, ifa.frame_err, ifa.break_det}), 16'b11);
    idle(10);
    lit("break_rehunt", 16'(state_of(0)), 16'd1);

    // recovery frame, correct even parity
    frame(0, 8, 1, 1, 9'h03C, 1'b0, 2'b11, -1);
    drain(0);
    lit("even_ok_perr", 16'(ifa.parity_err), 16'd0);
    lit("even_ok_data", 16'(ifa.data_out), 16'h003C);

    // enable dropped during data bit 4
    f = frame_bits(8, 1, 1, 9'h0FF, 1'b0, 2'b11, n);
    send(0, f, n, -1, 5);
    idle(5);
    set_en(0, 1'b1);
    idle(40);
    lit("abort_keeps_data", 16'(ifa.data_out), 16'h003C);
    lit("abort_no_pulse", 16'(pulses[0]), 16'd5);
    lit("abort_rehunt", 16'(state_of(0)), 16'd1);

    // 7N2 back-to-back frames
    frame(2, 7, 0, 2, 9'h041, 1'b0, 2'b11, -1);
    frame(2, 7, 0, 2, 9'h07F, 1'b0, 2'b11, -1);
    drain(2);
    lit("b2b_last_data", 16'(ifc.data_out), 16'h007F);
    lit("b2b_pulses", 16'(pulses[2]), 16'd2);
    lit("b2b_parity_bit", 16'(ifc.parity_bit), 16'd0);

    idle(20);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Parametrised oversampling UART receiver; successor to the fixed 8-bit, even-parity receiver.
- Runs on clk_baud, driven by the baud generator at OVERSAMPLE × bit rate.
- Features:
  - 2-flop input synchroniser.
  - Mid-bit 3-sample majority vote.
  - False-start rejection.
  - Configurable data bits, parity mode and stop bits.
  - Parity, framing and break error flags, reported alongside the received word.

Parameters:
- DATA_BITS, 8, data bits per frame; legal 5..9; sent LSB first.
- OVERSAMPLE, 16, clk_baud cycles per bit; legal 8..32, must be even.
- PARITY_MODE, 1, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits checked; legal 1 or 2.

Ports:
- clk_baud  in  1  oversampled baud clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- rx  in  1  asynchronous serial line; idle high.
- tx_rx_start  in  1  receiver enable; low forces IDLE.
- rx_done  out  1  one-cycle pulse; frame complete, data_out and flags valid.
- data_out  out  DATA_BITS  received word; held until the next rx_done.
- parity_bit  out  1  received parity bit; 0 when PARITY_MODE = 0.
- parity_err  out  1  parity mismatch for the last frame; held with data_out.
- frame_err  out  1  a stop bit sampled 0; held with data_out.
- break_det  out  1  all data bits, parity and stop bits sampled 0; held with data_out.
- current_state_rx  out  3  FSM state, for debug.

Behaviour:
- Reset (rst = 1 at an edge):
  - State IDLE.
  - rx_done, data_out, parity_bit, parity_err, frame_err and break_det all 0.
  - Synchroniser flops preset to 1.
  - All counters 0.
- Synchroniser: rx_s = rx delayed 2 cycles. All FSM decisions use rx_s only.
- Sample counter sc, range 0..OVERSAMPLE-1, decision point MID = OVERSAMPLE/2:
  - Samples are taken at sc = MID-1, MID and MID+1.
  - The bit value is the majority of the three, registered at sc = MID+1.
- States:
  - IDLE (0): waits for tx_rx_start = 1 and rx_s = 1. Then goes to HUNT.
  - HUNT (1):
    - On rx_s = 0: sc cleared, goes to START.
  - START (2):
    - At sc = MID+1, majority 1: false start, return to HUNT, no output change.
    - At sc = MID+1, majority 0: go to DATA, with bit counter bc = 0 and the bit-phase reference kept so that sc wraps from OVERSAMPLE-1 to 0.
  - DATA (3):
    - Each voted bit shifts into the MSB of the shift register; LSB arrives first.
    - After bit DATA_BITS-1: go to PARITY, or to STOP if PARITY_MODE = 0.
  - PARITY (4):
    - Voted bit is captured.
    - Expected bit = XOR of data bits, inverted when PARITY_MODE = 2.
  - STOP (5):
    - Runs STOP_BITS times.
    - Any voted 0 sets the pending frame error.
    - After the decision on the last stop bit, the next cycle:
      - drive rx_done = 1;
      - update data_out, parity_bit and all three flags together;
      - go to HUNT if no break, else to IDLE.
    - rx_done does not wait for the end of the stop bit, so a back-to-back start bit is caught.
- Break: break_det = 1 implies frame_err = 1 and data_out = 0. The break case returns to IDLE, which requires rx_s = 1 before hunting resumes.
- Outputs change only on rx_done. Between frames they hold their values, and rx_done is 0.
- tx_rx_start = 0 in any state (mid-frame included) goes to IDLE next cycle:
  - partial frame discarded;
  - no rx_done;
  - held outputs unchanged.
- rst mid-frame: full reset as above, no rx_done.
- Illegal state encodings go to IDLE.
- Bit counter width: $clog2(DATA_BITS+1). Sample counter width: $clog2(OVERSAMPLE).

Decomposition:
- Package uart_pkg holds:
  - state localparams IDLE..STOP (3-bit);
  - PARITY_NONE/EVEN/ODD constants;
  - a function computing expected parity from data and mode.
- One sub-module: uart_rx_sampler. It contains the 2-flop synchroniser, the sc counter and the 3-sample majority vote. Its outputs are rx_s, bit_val and a bit_tick pulse at sc = MID+1. It takes a restart input that clears sc.
- The FSM stays in uart_rx_os.

Test Plan:
- Reset then idle: rst high 2 cycles, rx = 1, tx_rx_start = 1 → outputs all 0, state = HUNT (1) 1 cycle after leaving IDLE, rx_done never pulses.
- Nominal frame, defaults: byte 0xA5, even parity bit 0, 1 stop bit, each bit held 16 cycles → rx_done exactly one pulse, data_out = 0xA5, parity_bit = 0, all error flags 0.
- Parity error:
  - PARITY_MODE = 2: 0xA5 sent with parity bit 0 → parity_err = 1, data_out = 0xA5.
  - PARITY_MODE = 1: 0x3C sent with parity 0 → parity_err = 0.
- Glitch rejection and false start:
  - rx low for 4 cycles only → back to HUNT, no rx_done.
  - 1-cycle glitch at sc = MID inside data bit 3 of 0x00 → still data_out = 0x00 via majority vote.
- Framing and break:
  - Stop bit sent as 0 for 0x55 → frame_err = 1, break_det = 0, data_out = 0x55.
  - rx held low 200 cycles → break_det = 1, frame_err = 1, data_out = 0x00; no new frame until rx returns high.
- Config and abort:
  - DATA_BITS = 7, STOP_BITS = 2, PARITY_MODE = 0: back-to-back frames 0x41 then 0x7F → two rx_done pulses in order.
  - Separately, tx_rx_start dropped during data bit 4 → state IDLE next cycle, no rx_done, previous data_out retained.
